// File: rtl/alu_share_arb.sv
// alu_share_arb
//   Two-port arbiter/sequencer for a shared 32-bit ALU. Each port issues an
//   operation (in1, in2, ctrl, sign) over valid/ready. One operation runs at a
//   time: IDLE accepts, EXEC lets the ALU see the registered operands and
//   captures its result, RESP returns the result to the owning port.
//
// Ports
//   clk, reset_n                 clock, async active-low reset
//   reqN_valid/ready             request handshake, N = 0,1
//   reqN_in1/in2/ctrl/sign       request payload
//   respN_valid/ready            response handshake
//   respN_data/zero              captured ALU result and zero flag
//   alu_in1/in2/ctrl/sign        shared ALU operands (always from op register)
//   alu_out/alu_zero             ALU result, combinational from alu_*
//
// Parameter
//   RR  1 = round-robin, 0 = fixed priority with port 0 winning

module alu_share_arb #(
  parameter bit RR = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  // port 0 request
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_in1,
  input  logic [31:0] req0_in2,
  input  logic [4:0]  req0_ctrl,
  input  logic        req0_sign,
  // port 1 request
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_in1,
  input  logic [31:0] req1_in2,
  input  logic [4:0]  req1_ctrl,
  input  logic        req1_sign,
  // port 0 response
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_data,
  output logic        resp0_zero,
  // port 1 response
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_data,
  output logic        resp1_zero,
  // shared ALU
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [4:0]  alu_ctrl,
  output logic        alu_sign,
  input  logic [31:0] alu_out,
  input  logic        alu_zero
);

  localparam int NUM_PORTS = 2;

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  ctrl;
    logic        sign;
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  op_t [NUM_PORTS-1:0]   req_op;
  logic [NUM_PORTS-1:0]  req_vld, req_rdy;
  logic [NUM_PORTS-1:0]  resp_vld, resp_rdy;

  op_t         op_q;
  logic        owner_q;
  logic        last_grant_q;
  logic [31:0] res_q;
  logic        zero_q;

  logic        win;
  logic        accept;
  logic        resp_fire;

  // Gather per-port signals into arrays so the core logic is port-indexed.
  assign req_vld   = {req1_valid, req0_valid};
  assign resp_rdy  = {resp1_ready, resp0_ready};
  assign req_op[0] = '{in1: req0_in1, in2: req0_in2, ctrl: req0_ctrl, sign: req0_sign};
  assign req_op[1] = '{in1: req1_in1, in2: req1_in2, ctrl: req1_ctrl, sign: req1_sign};

  assign {req1_ready, req0_ready}   = req_rdy;
  assign {resp1_valid, resp0_valid} = resp_vld;

  // Both ports see the same result register; only the owner's valid is raised.
  assign resp0_data = res_q;
  assign resp1_data = res_q;
  assign resp0_zero = zero_q;
  assign resp1_zero = zero_q;

  assign alu_in1  = op_q.in1;
  assign alu_in2  = op_q.in2;
  assign alu_ctrl = op_q.ctrl;
  assign alu_sign = op_q.sign;

  // Winner among valid ports. Under contention round-robin picks the port
  // that did not win last time; fixed priority keeps port 0.
  always_comb begin
    win = 1'b0;
    if (req_vld[1] && !req_vld[0])
      win = 1'b1;
    else if ((&req_vld) && RR)
      win = ~last_grant_q;
  end

  assign accept    = (state_q == S_IDLE) && (|req_vld);
  assign resp_fire = (state_q == S_RESP) && resp_rdy[owner_q];

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)    state_d = S_EXEC;
      S_EXEC:                 state_d = S_RESP;
      S_RESP:  if (resp_fire) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_rdy  = '0;
    resp_vld = '0;
    if (state_q == S_IDLE && (|req_vld)) req_rdy[win]      = 1'b1;
    if (state_q == S_RESP)               resp_vld[owner_q] = 1'b1;
  end

  // Operand / ownership registers. last_grant resets to 1 so port 0 takes
  // the first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q         <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      op_q         <= req_op[win];
      owner_q      <= win;
      last_grant_q <= win;
    end
  end

  // Result capture at the end of EXEC; held through RESP and afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q  <= '0;
      zero_q <= 1'b0;
    end else if (state_q == S_EXEC) begin
      res_q  <= alu_out;
      zero_q <= alu_zero;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [4:0]  req0_ctrl, req1_ctrl;
  logic        req0_sign, req1_sign;
  logic        resp0_ready, resp1_ready;

  // round-robin instance outputs
  logic        r_req0_ready, r_req1_ready, r_resp0_valid, r_resp1_valid;
  logic [31:0] r_resp0_data, r_resp1_data;
  logic        r_resp0_zero, r_resp1_zero;
  logic [31:0] r_alu_in1, r_alu_in2, r_alu_out;
  logic [4:0]  r_alu_ctrl;
  logic        r_alu_sign, r_alu_zero;

  // fixed-priority instance outputs
  logic        f_req0_ready, f_req1_ready, f_resp0_valid, f_resp1_valid;
  logic [31:0] f_resp0_data, f_resp1_data;
  logic        f_resp0_zero, f_resp1_zero;
  logic [31:0] f_alu_in1, f_alu_in2, f_alu_out;
  logic [4:0]  f_alu_ctrl;
  logic        f_alu_sign, f_alu_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference ALU: add, sub, xor, slt(signed/unsigned), sll; others give 0.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] c, input logic s);
    case (c)
      5'b00000: return a + b;
      5'b00001: return a - b;
      5'b00100: return a ^ b;
      5'b00111: return s ? {31'b0, $signed(a) < $signed(b)} : {31'b0, a < b};
      5'b11001: return b << a[4:0];
      default:  return 32'h0;
    endcase
  endfunction

  assign r_alu_out  = alu_f(r_alu_in1, r_alu_in2, r_alu_ctrl, r_alu_sign);
  assign r_alu_zero = (r_alu_out == 32'h0);
  assign f_alu_out  = alu_f(f_alu_in1, f_alu_in2, f_alu_ctrl, f_alu_sign);
  assign f_alu_zero = (f_alu_out == 32'h0);

  alu_share_arb #(.RR(1'b1)) dut_rr (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(r_req0_ready), .req0_in1(req0_in1),
    .req0_in2(req0_in2), .req0_ctrl(req0_ctrl), .req0_sign(req0_sign),
    .req1_valid(req1_valid), .req1_ready(r_req1_ready), .req1_in1(req1_in1),
    .req1_in2(req1_in2), .req1_ctrl(req1_ctrl), .req1_sign(req1_sign),
    .resp0_valid(r_resp0_valid), .resp0_ready(resp0_ready),
    .resp0_data(r_resp0_data), .resp0_zero(r_resp0_zero),
    .resp1_valid(r_resp1_valid), .resp1_ready(resp1_ready),
    .resp1_data(r_resp1_data), .resp1_zero(r_resp1_zero),
    .alu_in1(r_alu_in1), .alu_in2(r_alu_in2), .alu_ctrl(r_alu_ctrl),
    .alu_sign(r_alu_sign), .alu_out(r_alu_out), .alu_zero(r_alu_zero)
  );

  alu_share_arb #(.RR(1'b0)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_in1(req0_in1),
    .req0_in2(req0_in2), .req0_ctrl(req0_ctrl), .req0_sign(req0_sign),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_in1(req1_in1),
    .req1_in2(req1_in2), .req1_ctrl(req1_ctrl), .req1_sign(req1_sign),
    .resp0_valid(f_resp0_valid), .resp0_ready(resp0_ready),
    .resp0_data(f_resp0_data), .resp0_zero(f_resp0_zero),
    .resp1_valid(f_resp1_valid), .resp1_ready(resp1_ready),
    .resp1_data(f_resp1_data), .resp1_zero(f_resp1_zero),
    .alu_in1(f_alu_in1), .alu_in2(f_alu_in2), .alu_ctrl(f_alu_ctrl),
    .alu_sign(f_alu_sign), .alu_out(f_alu_out), .alu_zero(f_alu_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] c, input logic s);
    if (p == 0) begin
      req0_in1 = a; req0_in2 = b; req0_ctrl = c; req0_sign = s; req0_valid = 1'b1;
    end else begin
      req1_in1 = a; req1_in2 = b; req1_ctrl = c; req1_sign = s; req1_valid = 1'b1;
    end
  endtask

  // Single-requester operation on the round-robin instance, starting in IDLE.
  task automatic do_op(input string tag, input int p, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] c, input logic s,
                       input logic [31:0] exp_d, input logic exp_z);
    set_req(p, a, b, c, s);
    #1;
    chk({tag, "_rdy_win"},  (p == 0) ? r_req0_ready : r_req1_ready, 1);
    chk({tag, "_rdy_lose"}, (p == 0) ? r_req1_ready : r_req0_ready, 0);
    tick();                                   // EXEC
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk({tag, "_exec_in1"},  r_alu_in1, a);
    chk({tag, "_exec_ctrl"}, {27'b0, r_alu_ctrl}, {27'b0, c});
    chk({tag, "_exec_vld"},  {31'b0, r_resp0_valid | r_resp1_valid}, 0);
    tick();                                   // RESP
    chk({tag, "_resp_vld"},   (p == 0) ? r_resp0_valid : r_resp1_valid, 1);
    chk({tag, "_resp_other"}, (p == 0) ? r_resp1_valid : r_resp0_valid, 0);
    chk({tag, "_data"}, (p == 0) ? r_resp0_data : r_resp1_data, exp_d);
    chk({tag, "_zero"}, (p == 0) ? r_resp0_zero : r_resp1_zero, exp_z);
    if (p == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
    tick();                                   // IDLE
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    #1;
    chk({tag, "_done_vld"}, {31'b0, r_resp0_valid | r_resp1_valid}, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
  endtask

  logic [31:0] exp_data [3];
  int          exp_port [3];

  initial begin
    reset_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_in1 = 0; req0_in2 = 0; req0_ctrl = 0; req0_sign = 0;
    req1_in1 = 0; req1_in2 = 0; req1_ctrl = 0; req1_sign = 0;
    resp0_ready = 0; resp1_ready = 0;
    #3;
    // reset state
    chk("rst_resp0_vld", r_resp0_valid, 0);
    chk("rst_resp1_vld", r_resp1_valid, 0);
    chk("rst_alu_in1",   r_alu_in1, 0);
    chk("rst_alu_in2",   r_alu_in2, 0);
    chk("rst_resp_data", r_resp0_data, 0);
    chk("rst_resp_zero", r_resp0_zero, 0);
    chk("rst_ready",     {31'b0, r_req0_ready | r_req1_ready}, 0);
    tick();
    reset_n = 1'b1;

    // basic operations
    do_op("add0",  0, 32'd3, 32'd5, 5'b00000, 1'b0, 32'd8, 1'b0);
    do_op("slt_s", 1, 32'hFFFF_FFFF, 32'd1, 5'b00111, 1'b1, 32'd1, 1'b0);
    do_op("slt_u", 1, 32'hFFFF_FFFF, 32'd1, 5'b00111, 1'b0, 32'd0, 1'b1);

    // round-robin contention from reset
    do_reset();
    exp_port = '{0, 1, 0};
    exp_data = '{32'd6, 32'h0F, 32'd6};
    set_req(0, 32'd10, 32'd4, 5'b00001, 1'b0);
    set_req(1, 32'hF0, 32'hFF, 5'b00100, 1'b0);
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rr%0d_rdy0", k), r_req0_ready, (exp_port[k] == 0) ? 1 : 0);
      chk($sformatf("rr%0d_rdy1", k), r_req1_ready, (exp_port[k] == 1) ? 1 : 0);
      tick();
      tick();
      chk($sformatf("rr%0d_vld", k),
          (exp_port[k] == 0) ? r_resp0_valid : r_resp1_valid, 1);
      chk($sformatf("rr%0d_data", k),
          (exp_port[k] == 0) ? r_resp0_data : r_resp1_data, exp_data[k]);
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    resp0_ready = 0; resp1_ready = 0;

    // response backpressure
    set_req(0, 32'd3, 32'd5, 5'b00000, 1'b0);
    #1;
    chk("bp_acc0", r_req0_ready, 1);
    tick();                                   // EXEC
    req0_valid = 0;
    set_req(1, 32'hF0, 32'hFF, 5'b00100, 1'b0);
    #1;
    chk("bp_exec_rdy1", r_req1_ready, 0);
    tick();                                   // RESP
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_vld0", k), r_resp0_valid, 1);
      chk($sformatf("bp%0d_data", k), r_resp0_data, 32'd8);
      chk($sformatf("bp%0d_rdy1", k), r_req1_ready, 0);
      tick();
    end
    resp0_ready = 1'b1;
    #1;
    chk("bp_hold_rdy1", r_req1_ready, 0);
    tick();                                   // first IDLE
    resp0_ready = 1'b0;
    #1;
    chk("bp_idle_rdy1", r_req1_ready, 1);
    chk("bp_idle_vld0", r_resp0_valid, 0);
    tick();                                   // EXEC
    req1_valid = 0;
    tick();                                   // RESP
    chk("bp_p1_vld",  r_resp1_valid, 1);
    chk("bp_p1_data", r_resp1_data, 32'h0F);
    resp1_ready = 1'b1;
    tick();
    resp1_ready = 1'b0;

    // reset during EXEC
    set_req(0, 32'd7, 32'd9, 5'b00000, 1'b1);
    tick();                                   // EXEC
    req0_valid = 0;
    reset_n = 1'b0;
    #1;
    chk("mid_vld",  {31'b0, r_resp0_valid | r_resp1_valid}, 0);
    chk("mid_in1",  r_alu_in1, 0);
    chk("mid_in2",  r_alu_in2, 0);
    chk("mid_ctrl", {27'b0, r_alu_ctrl}, 0);
    chk("mid_sign", r_alu_sign, 0);
    reset_n = 1'b1;
    tick();
    chk("mid_no_resp", {31'b0, r_resp0_valid | r_resp1_valid}, 0);
    do_op("sll1", 1, 32'h8000_0000, 32'd0, 5'b11001, 1'b0, 32'd0, 1'b1);

    // fixed priority starvation
    do_reset();
    set_req(0, 32'd10, 32'd4, 5'b00001, 1'b0);
    set_req(1, 32'hF0, 32'hFF, 5'b00100, 1'b0);
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("fp%0d_rdy0", k), f_req0_ready, 1);
      chk($sformatf("fp%0d_rdy1_a", k), f_req1_ready, 0);
      tick();
      chk($sformatf("fp%0d_rdy1_b", k), f_req1_ready, 0);
      tick();
      chk($sformatf("fp%0d_rdy1_c", k), f_req1_ready, 0);
      chk($sformatf("fp%0d_vld0", k), f_resp0_valid, 1);
      chk($sformatf("fp%0d_vld1", k), f_resp1_valid, 0);
      chk($sformatf("fp%0d_data", k), f_resp0_data, 32'd6);
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    resp0_ready = 0; resp1_ready = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
